// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter fed by a write-side FIFO. A master pushes payload words
// whenever the FIFO has room. The transmitter serialises them as frames:
//   start bit, DATA_BITS data bits sent LSB first, an optional parity bit,
//   and then one or two stop bits.
// When the FIFO still holds data at the end of a stop bit, the next frame
// starts immediately, with no idle gap between frames.
//
// Ports
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   prescaler   clocks per serial bit (0 behaves as 1)
//   parity_en   append a parity bit after the data bits
//   parity_odd  parity sense: 0 even, 1 odd
//   two_stop    send two stop bits instead of one
//   wr_en       push wr_data this cycle
//   wr_data     payload word
//   tx_pin      serial line, idle high
//   uart_busy   transmitter active or FIFO not empty
//   fifo_full   FIFO holds 2**ADDR_W entries
//   fifo_empty  FIFO holds no entries
//   fifo_level  current entry count
//   overflow    single-cycle flag: this cycle's write was dropped (FIFO full)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int ADDR_W      = 4,
    parameter int PRESCALER_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PRESCALER_W-1:0] prescaler,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    input  logic                   two_stop,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    output logic                   tx_pin,
    output logic                   uart_busy,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [ADDR_W:0]        fifo_level,
    output logic                   overflow
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int                 DEPTH     = 1 << ADDR_W;
    localparam int                 IDX_W     = 4;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [ADDR_W:0]    DEPTH_LVL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [ADDR_W:0]        level;
    logic [DATA_BITS-1:0]   head;
    logic                   push;
    logic                   pop;

    state_t                 state, state_n;
    logic [PRESCALER_W-1:0] cnt, cnt_n;
    logic [PRESCALER_W-1:0] p_l, p_l_n;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   par_en_l, par_en_n;
    logic                   par_bit_l, par_bit_n;
    logic                   two_stop_l, two_stop_n;
    logic                   tx_q, tx_n;
    logic                   bit_done;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == DEPTH_LVL);
    assign fifo_level = level;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push       = wr_en && (!fifo_full || pop);
    assign overflow   = wr_en && !push;
    assign uart_busy  = (state != IDLE) || !fifo_empty;
    assign tx_pin     = tx_q;
    // p_l is never 0; the load clamps a zero prescaler to 1.
    assign bit_done   = (cnt == p_l - PRESCALER_W'(1));

    // The payload storage has no reset. After reset, the pointers make the old
    // contents unreachable.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy. Both pointers wrap naturally at 2**ADDR_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Transmitter state register. tx_pin is registered so the line is glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            p_l        <= PRESCALER_W'(1);
            bit_idx    <= '0;
            shreg      <= '0;
            par_en_l   <= 1'b0;
            par_bit_l  <= 1'b0;
            two_stop_l <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            p_l        <= p_l_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            par_en_l   <= par_en_n;
            par_bit_l  <= par_bit_n;
            two_stop_l <= two_stop_n;
            tx_q       <= tx_n;
        end
    end

    // Next-state logic. tx_n is the value the line shows during the next
    // state, so the start bit appears on the same edge that pops the FIFO.
    // In STOP, bit_idx counts the first and second stop bit.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        p_l_n      = p_l;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        par_en_n   = par_en_l;
        par_bit_n  = par_bit_l;
        two_stop_n = two_stop_l;
        tx_n       = tx_q;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                    tx_n      = shreg[0];
                end else begin
                    cnt_n = cnt + PRESCALER_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_n = '0;
                        if (par_en_l) begin
                            state_n = PARITY;
                            tx_n    = par_bit_l;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                    end
                end else begin
                    cnt_n = cnt + PRESCALER_W'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = STOP;
                    tx_n      = 1'b1;
                end else begin
                    cnt_n = cnt + PRESCALER_W'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_done) begin
                    cnt_n = '0;
                    if (two_stop_l && (bit_idx == '0)) begin
                        bit_idx_n = IDX_W'(1);
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + PRESCALER_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Every pop starts a new frame and snapshots that frame's configuration.
        if (pop) begin
            state_n    = START;
            cnt_n      = '0;
            bit_idx_n  = '0;
            shreg_n    = head;
            p_l_n      = (prescaler == '0) ? PRESCALER_W'(1) : prescaler;
            par_en_n   = parity_en;
            par_bit_n  = (^head) ^ parity_odd;
            two_stop_n = two_stop;
            tx_n       = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo.
// Each accepted write pushes its expected frame onto a scoreboard queue.
// The bench advances one clock per call to stepCycle. On every call it
// decodes tx_pin at the falling clock edge. When it sees a start bit it pops
// the expected frame, compares every line sample against the ideal waveform,
// and compares the decoded payload with the expected data.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DATA_BITS = 8;
    localparam int ADDR_W    = 4;

    typedef struct {
        logic [8:0] data;
        int         p;
        bit         par_en;
        bit         par_odd;
        bit         two_stop;
    } frame_t;

    logic              clock;
    logic              reset;
    logic [15:0]       prescaler;
    logic              parity_en;
    logic              parity_odd;
    logic              two_stop;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              tx_pin;
    logic              uart_busy;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_level;
    logic              overflow;

    int          total;
    int          bad;
    int          cyc;
    int          unexpected;
    frame_t      sb[$];
    frame_t      cur;
    bit          mon_active;
    int          mon_off;
    int          mon_nbits;
    int          mon_errs;
    logic [15:0] mon_bits;
    logic [8:0]  mon_dec;
    int          last_start;
    int          prev_start;
    int          prev_len;
    bit          have_prev;
    bit          b2b;
    int          drop;

    uart_tx_fifo #(
        .DATA_BITS(DATA_BITS),
        .ADDR_W(ADDR_W),
        .PRESCALER_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .prescaler(prescaler),
        .parity_en(parity_en),
        .parity_odd(parity_odd),
        .two_stop(two_stop),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .tx_pin(tx_pin),
        .uart_busy(uart_busy),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_level(fifo_level),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and update the serial-line monitor at the falling edge.
    task automatic stepCycle();
        int bit_i;
        int n;
        @(negedge clock);
        cyc++;
        if (reset) begin
            mon_active = 1'b0;
            return;
        end
        if (!mon_active && tx_pin === 1'b0) begin
            if (sb.size() == 0) begin
                unexpected++;
            end else begin
                cur = sb.pop_front();
                mon_bits = '1;
                mon_bits[0] = 1'b0;
                for (int i = 0; i < DATA_BITS; i++) mon_bits[1 + i] = cur.data[i];
                n = 1 + DATA_BITS;
                if (cur.par_en) begin
                    mon_bits[n] = (^cur.data[DATA_BITS-1:0]) ^ cur.par_odd;
                    n++;
                end
                n = n + 1 + int'(cur.two_stop);
                mon_nbits = n;
                if (b2b && have_prev) checkOutput("frame_gap", cyc - prev_start, prev_len);
                prev_start = cyc;
                prev_len   = n * cur.p;
                have_prev  = 1'b1;
                last_start = cyc;
                mon_active = 1'b1;
                mon_off    = 0;
                mon_errs   = 0;
                mon_dec    = '0;
            end
        end
        if (mon_active) begin
            bit_i = mon_off / cur.p;
            if (tx_pin !== mon_bits[bit_i]) mon_errs++;
            if ((mon_off % cur.p) == (cur.p / 2) && bit_i >= 1 && bit_i <= DATA_BITS)
                mon_dec[bit_i - 1] = tx_pin;
            if (mon_off == mon_nbits * cur.p - 1) begin
                checkOutput("frame_wave", mon_errs, 0);
                checkOutput("frame_data", mon_dec, cur.data);
                mon_active = 1'b0;
            end else begin
                mon_off++;
            end
        end
    endtask

    // Drive one write for a clock. When the write is expected to be accepted,
    // push its expected frame onto the scoreboard.
    task automatic applyStimulus(input logic [7:0] d, input bit accept);
        frame_t f;
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) begin
            f.data     = {1'b0, d};
            f.p        = (prescaler == 16'd0) ? 1 : int'(prescaler);
            f.par_en   = parity_en;
            f.par_odd  = parity_odd;
            f.two_stop = two_stop;
            sb.push_back(f);
        end
        #1;
        checkOutput("overflow", overflow, 32'(!accept));
        stepCycle();
        wr_en = 1'b0;
    endtask

    task automatic waitIdle(input int bound, output int drop_cyc);
        for (int i = 0; i < bound && uart_busy !== 1'b0; i++) stepCycle();
        drop_cyc = cyc;
        checkOutput("busy_idle", uart_busy, 0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; unexpected = 0;
        mon_active = 0; have_prev = 0; b2b = 0;
        reset = 1'b1; prescaler = 16'd4; parity_en = 0; parity_odd = 0; two_stop = 0;
        wr_en = 0; wr_data = '0;

        // Reset state
        repeat (3) stepCycle();
        checkOutput("rst_tx", tx_pin, 1);
        checkOutput("rst_busy", uart_busy, 0);
        checkOutput("rst_full", fifo_full, 0);
        checkOutput("rst_empty", fifo_empty, 1);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_ovf", overflow, 0);
        reset = 1'b0;
        repeat (2) stepCycle();

        // 8N1 at P=4, payload 0x55, plus the one-clock start latency
        $display("[TB] 8N1 prescaler 4");
        applyStimulus(8'h55, 1);
        checkOutput("land_tx", tx_pin, 1);
        checkOutput("land_level", fifo_level, 1);
        checkOutput("land_busy", uart_busy, 1);
        stepCycle();
        checkOutput("start_tx", tx_pin, 0);
        checkOutput("start_level", fifo_level, 0);
        waitIdle(200, drop);
        checkOutput("len_8n1", drop - last_start, 40);

        // Even and then odd parity on 0x07
        $display("[TB] parity");
        parity_en = 1'b1; parity_odd = 1'b0;
        applyStimulus(8'h07, 1);
        waitIdle(200, drop);
        checkOutput("len_even", drop - last_start, 44);
        parity_odd = 1'b1;
        applyStimulus(8'h07, 1);
        waitIdle(200, drop);
        checkOutput("len_odd", drop - last_start, 44);
        parity_en = 1'b0; parity_odd = 1'b0;

        // Burst of 18 writes at P=100: the 17th fills the FIFO, the 18th overflows
        $display("[TB] burst and overflow");
        prescaler = 16'd100; b2b = 1'b1; have_prev = 1'b0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(8'(i), i < 17);
            if (i == 16) begin
                checkOutput("burst_level", fifo_level, 16);
                checkOutput("burst_full", fifo_full, 1);
            end
        end
        #1;
        checkOutput("ovf_clear", overflow, 0);
        checkOutput("ovf_level", fifo_level, 16);
        waitIdle(20000, drop);
        checkOutput("burst_sb", sb.size(), 0);
        b2b = 1'b0;

        // Two stop bits at P=3, two back-to-back frames
        $display("[TB] two stop bits");
        prescaler = 16'd3; two_stop = 1'b1; b2b = 1'b1; have_prev = 1'b0;
        applyStimulus(8'hFF, 1);
        applyStimulus(8'h00, 1);
        waitIdle(300, drop);
        checkOutput("len_2stop", drop - last_start, 33);
        b2b = 1'b0; two_stop = 1'b0;

        // Reset during the data bits, with 3 entries still queued
        $display("[TB] reset mid-frame");
        prescaler = 16'd4;
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 1);
        applyStimulus(8'h33, 1);
        applyStimulus(8'h44, 1);
        repeat (8) stepCycle();
        checkOutput("pre_rst_level", fifo_level, 3);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        sb.delete();
        checkOutput("mid_rst_tx", tx_pin, 1);
        checkOutput("mid_rst_empty", fifo_empty, 1);
        checkOutput("mid_rst_level", fifo_level, 0);
        checkOutput("mid_rst_busy", uart_busy, 0);
        repeat (60) stepCycle();
        checkOutput("post_rst_tx", tx_pin, 1);
        checkOutput("post_rst_busy", uart_busy, 0);

        // Prescaler 0 acts as 1 clock per bit
        $display("[TB] prescaler zero");
        prescaler = 16'd0;
        applyStimulus(8'hA3, 1);
        waitIdle(100, drop);
        checkOutput("len_p0", drop - last_start, 10);

        // A prescaler change mid-frame only affects the next frame
        $display("[TB] prescaler change mid-frame");
        prescaler = 16'd2;
        applyStimulus(8'h3C, 1);
        repeat (5) stepCycle();
        prescaler = 16'd7;
        waitIdle(200, drop);
        checkOutput("len_p2", drop - last_start, 20);
        applyStimulus(8'h5A, 1);
        waitIdle(300, drop);
        checkOutput("len_p7", drop - last_start, 70);

        checkOutput("unexpected_frames", unexpected, 0);
        checkOutput("sb_final", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
